// File: rtl/ysyx_22040632_burst_mem_slave.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : ysyx_22040632_burst_mem_slave
// Purpose  : Responder end of the cache/memory burst interface. Serves
//            single-beat or INCR burst reads/writes from an internal
//            64-bit-wide memory, producing per-beat handshakes and the
//            end-of-transaction rw_ready pulse.
// Ports    : clk, rst (sync, active-high)
//            rw_valid/rw_req/rw_addr/rw_size/rw_len  - request
//            rw_w_data/w_strb/w_last                 - write beat data
//            rw_ready, data_read, r_hs, r_last, w_hs - responses
//            axi_write_ahead                         - write pre-fetch hint
//            protocol_err                            - sticky w_last/len mismatch
// Options  : YSYX_22040632_MEM_SLAVE_DELAY_EN - ADDR phase lasts DELAY+1
//            cycles instead of one.
// Revision : 1.0 - initial release
//============================================================================

`ifndef ysyx_22040632_REQ_READ
`define ysyx_22040632_REQ_READ  1'b0
`endif
`ifndef ysyx_22040632_REQ_WRITE
`define ysyx_22040632_REQ_WRITE 1'b1
`endif

module ysyx_22040632_burst_mem_slave #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12,
    parameter int DELAY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rw_valid,
    input  logic        rw_req,
    input  logic [31:0] rw_addr,
    input  logic [2:0]  rw_size,
    input  logic [7:0]  rw_len,
    input  logic [63:0] rw_w_data,
    input  logic [7:0]  w_strb,
    input  logic        w_last,
    output logic        rw_ready,
    output logic [63:0] data_read,
    output logic        r_hs,
    output logic        r_last,
    output logic        w_hs,
    output logic        axi_write_ahead,
    output logic        protocol_err
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_addr  = 3'd1;
    localparam logic [2:0] c_st_rdata = 3'd2;
    localparam logic [2:0] c_st_wdata = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_next_state;
    logic          r_req;
    logic [AW-1:0] r_index;
    logic [7:0]    r_len;
    logic [7:0]    r_beat;
    logic          r_protocol_err;
    logic [63:0]   r_mem [DEPTH];

    logic [AW-1:0] w_addr;
    logic          w_last_beat;
    logic          w_addr_done;
    logic          w_unused;

    // Beat address wraps naturally at DEPTH through AW-bit truncation.
    assign w_addr      = r_index + AW'(r_beat);
    assign w_last_beat = (r_beat == r_len);

    // Size is informational and the byte offset is irrelevant to a
    // word-wide store; fold them away explicitly.
    assign w_unused = ^{rw_size, rw_addr[31:AW+3], rw_addr[2:0]} ^ (DELAY != 0);

`ifdef YSYX_22040632_MEM_SLAVE_DELAY_EN
    logic [7:0] r_dly;

    assign w_addr_done = (r_dly == 8'(DELAY));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dly <= 8'd0;
        end else if (r_state == c_st_addr && !w_addr_done) begin
            r_dly <= r_dly + 8'd1;
        end else begin
            r_dly <= 8'd0;
        end
    end
`else
    assign w_addr_done = 1'b1;
`endif

    assign protocol_err = r_protocol_err;

    // State register and request context.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_st_idle;
            r_req          <= `ysyx_22040632_REQ_READ;
            r_index        <= '0;
            r_len          <= 8'd0;
            r_beat         <= 8'd0;
            r_protocol_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                c_st_idle: begin
                    if (rw_valid) begin
                        r_req   <= rw_req;
                        r_index <= rw_addr[AW+2:3];
                        r_len   <= rw_len;
                        r_beat  <= 8'd0;
                    end
                end
                c_st_rdata: begin
                    r_beat <= r_beat + 8'd1;
                end
                c_st_wdata: begin
                    r_beat <= r_beat + 8'd1;
                    // Mismatch either way: early w_last, or len reached
                    // without w_last.
                    if (w_last != w_last_beat) begin
                        r_protocol_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Backing store write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && r_state == c_st_wdata) begin
            for (int i = 0; i < 8; i++) begin
                if (w_strb[i]) begin
                    r_mem[w_addr][8*i +: 8] <= rw_w_data[8*i +: 8];
                end
            end
        end
    end

    // Next-state and outputs.
    always_comb begin
        w_next_state    = r_state;
        rw_ready        = 1'b0;
        data_read       = 64'd0;
        r_hs            = 1'b0;
        r_last          = 1'b0;
        w_hs            = 1'b0;
        axi_write_ahead = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (rw_valid) begin
                    w_next_state = c_st_addr;
                end
            end
            c_st_addr: begin
                if (w_addr_done) begin
                    axi_write_ahead = (r_req == `ysyx_22040632_REQ_WRITE);
                    w_next_state    = (r_req == `ysyx_22040632_REQ_WRITE) ? c_st_wdata : c_st_rdata;
                end
            end
            c_st_rdata: begin
                r_hs      = 1'b1;
                data_read = r_mem[w_addr];
                if (w_last_beat) begin
                    r_last       = 1'b1;
                    rw_ready     = 1'b1;
                    w_next_state = c_st_done;
                end
            end
            c_st_wdata: begin
                w_hs = 1'b1;
                if (w_last_beat || w_last) begin
                    rw_ready     = 1'b1;
                    w_next_state = c_st_done;
                end
            end
            c_st_done: begin
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040632_burst_mem_slave.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : tb_ysyx_22040632_burst_mem_slave
// Purpose  : Self-checking bench for ysyx_22040632_burst_mem_slave. Each
//            transaction task schedules the expected per-cycle outputs from
//            the protocol timing rules and a word-array memory model; one
//            compare process checks every cycle against that schedule.
// Revision : 1.0 - initial release
//============================================================================

`ifndef ysyx_22040632_REQ_READ
`define ysyx_22040632_REQ_READ  1'b0
`endif
`ifndef ysyx_22040632_REQ_WRITE
`define ysyx_22040632_REQ_WRITE 1'b1
`endif

module tb_ysyx_22040632_burst_mem_slave;

    localparam int DEPTH = 4096;
    localparam int AW    = 12;
`ifdef YSYX_22040632_MEM_SLAVE_DELAY_EN
    localparam int D   = 3;
    localparam int LAT = 5;
`else
    localparam int D   = 0;
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rw_valid = 1'b0;
    logic        rw_req = 1'b0;
    logic [31:0] rw_addr = 32'd0;
    logic [2:0]  rw_size = 3'd3;
    logic [7:0]  rw_len = 8'd0;
    logic [63:0] rw_w_data = 64'd0;
    logic [7:0]  w_strb = 8'd0;
    logic        w_last = 1'b0;
    logic        rw_ready;
    logic [63:0] data_read;
    logic        r_hs;
    logic        r_last;
    logic        w_hs;
    logic        axi_write_ahead;
    logic        protocol_err;

    always #5 clk = ~clk;

    ysyx_22040632_burst_mem_slave #(.DEPTH(DEPTH), .AW(AW), .DELAY(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .rw_valid       (rw_valid),
        .rw_req         (rw_req),
        .rw_addr        (rw_addr),
        .rw_size        (rw_size),
        .rw_len         (rw_len),
        .rw_w_data      (rw_w_data),
        .w_strb         (w_strb),
        .w_last         (w_last),
        .rw_ready       (rw_ready),
        .data_read      (data_read),
        .r_hs           (r_hs),
        .r_last         (r_last),
        .w_hs           (w_hs),
        .axi_write_ahead(axi_write_ahead),
        .protocol_err   (protocol_err)
    );

    typedef struct packed {
        logic        rdy;
        logic        rhs;
        logic        rlast;
        logic        whs;
        logic        aw;
        logic [63:0] data;
    } exp_t;

    exp_t        exp_tab[int];     // expected outputs keyed by cycle number
    bit          perr_set[int];    // protocol_err value taking effect at cycle
    bit          cur_perr = 1'b0;
    logic [63:0] model_mem[DEPTH];
    logic [63:0] rd_log[$];
    int          first_rhs = 0;
    int          last_req = 0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s @cycle %0d: got %h want %h", name, cyc, act, expv);
    endtask

    always @(negedge clk) begin : cmp
        exp_t e;
        if (cyc > 0) begin
            if (perr_set.exists(cyc)) begin
                cur_perr = perr_set[cyc];
                perr_set.delete(cyc);
            end
            e = '0;
            if (exp_tab.exists(cyc)) begin
                e = exp_tab[cyc];
                exp_tab.delete(cyc);
            end
            check("outputs{rdy,rhs,rlast,whs,aw,data}",
                  {rw_ready, r_hs, r_last, w_hs, axi_write_ahead, data_read}, e);
            check("protocol_err", 69'(protocol_err), 69'(cur_perr));
            if (r_hs === 1'b1) begin
                if (rd_log.size() == 0) first_rhs = cyc;
                rd_log.push_back(data_read);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // DONE cycle (valid ignored there), then drop valid and idle.
    task automatic finish_txn(input int gap);
        tick();
        rw_valid = 1'($urandom);
        w_last   = 1'b0;
        tick();
        rw_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input int gap, input int abort);
        int   c;
        int   idx;
        exp_t e;
        int   kill[$];
        c        = cyc;
        last_req = c;
        rw_valid = 1'b1;
        rw_req   = `ysyx_22040632_REQ_READ;
        rw_addr  = addr;
        rw_len   = len[7:0];
        rw_size  = 3'($urandom);
        idx      = int'(addr[AW+2:3]);
        for (int b = 0; b <= len; b++) begin
            e       = '0;
            e.rhs   = 1'b1;
            e.data  = model_mem[(idx + b) % DEPTH];
            e.rlast = (b == len);
            e.rdy   = (b == len);
            exp_tab[c + 2 + D + b] = e;
        end
        for (int k = 1; k <= 2 + D + len; k++) begin
            tick();
            rw_addr  = $urandom;
            rw_req   = 1'($urandom);
            rw_valid = 1'($urandom);
            if (abort >= 0 && k == 2 + D + abort) begin
                rst      = 1'b1;
                rw_valid = 1'b0;
                foreach (exp_tab[key]) if (key > cyc) kill.push_back(key);
                foreach (kill[j]) exp_tab.delete(kill[j]);
                perr_set[cyc + 1] = 1'b0;
                tick();
                rst = 1'b0;
                repeat (gap) tick();
                return;
            end
        end
        finish_txn(gap);
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input int wlast_at,
                            input logic [63:0] base, input logic [7:0] strb,
                            input bit rnd, input int gap);
        int          c;
        int          idx;
        int          n;
        int          b;
        exp_t        e;
        logic [63:0] d;
        logic [7:0]  s;
        c        = cyc;
        last_req = c;
        rw_valid = 1'b1;
        rw_req   = `ysyx_22040632_REQ_WRITE;
        rw_addr  = addr;
        rw_len   = len[7:0];
        w_last   = 1'b0;
        idx      = int'(addr[AW+2:3]);
        n        = (wlast_at < len) ? wlast_at + 1 : len + 1;
        e        = '0;
        e.aw     = 1'b1;
        exp_tab[c + 1 + D] = e;
        for (int i = 0; i < n; i++) begin
            e     = '0;
            e.whs = 1'b1;
            e.rdy = (i == n - 1);
            exp_tab[c + 2 + D + i] = e;
        end
        if (wlast_at != len) perr_set[c + 2 + D + n] = 1'b1;
        for (int k = 1; k <= 1 + D + n; k++) begin
            tick();
            rw_addr  = $urandom;
            rw_req   = 1'($urandom);
            rw_valid = 1'($urandom);
            if (k >= 2 + D) begin
                b         = k - 2 - D;
                d         = rnd ? {$urandom, $urandom} : base + 64'(b);
                s         = rnd ? 8'($urandom) : strb;
                rw_w_data = d;
                w_strb    = s;
                w_last    = (b == wlast_at);
                for (int i = 0; i < 8; i++)
                    if (s[i]) model_mem[(idx + b) % DEPTH][8*i +: 8] = d[8*i +: 8];
            end else begin
                w_last = 1'($urandom);
            end
        end
        finish_txn(gap);
    endtask

    initial begin
        int len;
        int wl;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]  = 64'h1000_0000_0000_0000 + 64'(i);
            dut.r_mem[i]  = 64'h1000_0000_0000_0000 + 64'(i);
        end
        model_mem[64] = 64'hFFFF_FFFF_FFFF_FFFF;
        dut.r_mem[64] = 64'hFFFF_FFFF_FFFF_FFFF;

        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Line read from 0x80.
        rd_log.delete();
        do_read(32'h80, 7, 0, -1);
        check("read beats", 69'(rd_log.size()), 69'(8));
        check("read beat0", 69'(rd_log[0]), 69'(64'h1000_0000_0000_0010));
        check("read beat7", 69'(rd_log[7]), 69'(64'h1000_0000_0000_0017));
        check("first beat latency", 69'(first_rhs - last_req), 69'(LAT));

        // Strobed single write, then read back.
        do_write(32'h200, 0, 0, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 1'b0, 1);
        rd_log.delete();
        do_read(32'h200, 0, 0, -1);
        check("strobed readback", 69'(rd_log[0]), 69'(64'hFFFF_FFFF_CCCC_DDDD));

        // Burst wrapping from index 4092.
        do_write(32'h7FE0, 7, 7, 64'hD000, 8'hFF, 1'b0, 0);
        check("perr after wrap", 69'(protocol_err), 69'(0));
        rd_log.delete();
        do_read(32'h0, 3, 2, -1);
        check("wrap idx0", 69'(rd_log[0]), 69'(64'hD004));
        check("wrap idx3", 69'(rd_log[3]), 69'(64'hD007));

        // Early w_last on beat 3 of an 8-beat write.
        do_write(32'h400, 7, 3, 64'hE000, 8'hFF, 1'b0, 0);
        check("perr early wlast", 69'(protocol_err), 69'(1));
        rd_log.delete();
        do_read(32'h400, 7, 0, -1);
        check("early term word3", 69'(rd_log[3]), 69'(64'hE003));
        check("early term word4", 69'(rd_log[4]), 69'(64'h1000_0000_0000_0084));

        // Reset during beat 3 of a read, then a clean read.
        do_read(32'h100, 7, 0, 3);
        check("perr after reset", 69'(protocol_err), 69'(0));
        rd_log.delete();
        do_read(32'h100, 7, 1, -1);
        check("post-reset beats", 69'(rd_log.size()), 69'(8));
        check("post-reset beat7", 69'(rd_log[7]), 69'(64'h1000_0000_0000_0027));

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            case ($urandom % 4)
                0: len = 0;
                1: len = 7;
                2: len = 3;
                default: len = int'($urandom % 16);
            endcase
            if ($urandom % 2 == 0) begin
                do_read($urandom, len, int'($urandom % 3), -1);
            end else begin
                case ($urandom % 5)
                    0: wl = int'($urandom % (len + 1));
                    1: wl = 255;
                    default: wl = len;
                endcase
                do_write($urandom, len, wl, 64'd0, 8'd0, 1'b1, int'($urandom % 3));
            end
        end
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
